// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the pipeline sequencing controller:
//   - FSM state encoding (INIT / RUN / DWAIT)
//   - REG_ZERO, the hard-wired zero register, which never creates a hazard
//   - ctrl_t, the bundle of pipeline control outputs, plus canned values
//   - load_use_hazard(), the EX-load versus ID-source comparison
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DWAIT = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic if_flush;
        logic id_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Fetch held, IF/ID flushed, bubbles into ID/EX; back end keeps draining.
    localparam ctrl_t CTRL_INIT = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b1,
                                    id_bubble: 1'b1, pipe_hold: 1'b0};
    // Whole pipeline frozen while data memory is busy.
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                      id_bubble: 1'b0, pipe_hold: 1'b1};
    // Hold PC and IF/ID, inject one bubble behind the load.
    localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                        id_bubble: 1'b1, pipe_hold: 1'b0};
    // Take the redirect and squash the wrong-path fetch.
    localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b1,
                                        id_bubble: 1'b0, pipe_hold: 1'b0};
    // Fetch not ready: keep PC, feed a NOP into ID so ID does not re-execute.
    localparam ctrl_t CTRL_FETCH_WAIT = '{pc_write: 1'b0, ifid_write: 1'b1, if_flush: 1'b1,
                                          id_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b0,
                                      id_bubble: 1'b0, pipe_hold: 1'b0};

    // A load in EX conflicts with ID when its destination is a live source of
    // the ID instruction. rt only counts when ID actually reads it.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones. A synchronous clear wins over
// an increment in the same cycle.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (count -> 0)
//   inc_i  : count this cycle
//   clr_i  : synchronous clear
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core.
//   Inputs : load-use operands (ID_rs_i, ID_rt_i, ID_uses_rt_i, EX_MemRead_i,
//            EX_rt_i), ID redirects (branch_taken_i, jump_i), fetch readiness
//            (imem_ready_i), data memory handshake (dmem_req_i, dmem_ack_i),
//            counter clear (clr_cnt_i).
//   Outputs: PCWrite_o, IF_IDWrite_o, IF_flush_o, ID_bubble_o, pipe_hold_o,
//            all combinational so they settle before the sampling edge;
//            stall_cnt_o / flush_cnt_o saturating performance counters.
// FSM: INIT flushes the front end for FLUSH_CYCLES cycles after reset, RUN is
// normal sequencing, DWAIT freezes everything until data memory acks.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_uses_rt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             clr_cnt_i,
    output logic             PCWrite_o,
    output logic             IF_IDWrite_o,
    output logic             IF_flush_o,
    output logic             ID_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int INIT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [INIT_W-1:0] init_cnt_q;
    logic [INIT_W-1:0] init_cnt_d;

    ctrl_t front_ctrl;
    ctrl_t ctrl;
    logic  redirect;
    logic  stall_inc;
    logic  flush_inc;

    // Front-end decision when the back end is not frozen. A load-use stall
    // outranks a redirect: the branch stays in ID and re-resolves next cycle
    // once the load value can be forwarded.
    always_comb begin
        front_ctrl = CTRL_NORMAL;
        redirect   = 1'b0;
        if (load_use_hazard(EX_MemRead_i, EX_rt_i, ID_rs_i, ID_rt_i, ID_uses_rt_i)) begin
            front_ctrl = CTRL_LOAD_USE;
        end else if (branch_taken_i || jump_i) begin
            front_ctrl = CTRL_REDIRECT;
            redirect   = 1'b1;
        end else if (!imem_ready_i) begin
            front_ctrl = CTRL_FETCH_WAIT;
        end
    end

    // State sequencing. In RUN a request without same-cycle ack freezes and
    // moves to DWAIT; DWAIT releases in the ack cycle, where the front end
    // gets its normal decision (a branch held during the freeze acts here).
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ctrl       = CTRL_INIT;
        flush_inc  = 1'b0;
        case (state_q)
            ST_INIT: begin
                ctrl = CTRL_INIT;
                if (init_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_DWAIT;
                end else begin
                    ctrl      = front_ctrl;
                    flush_inc = redirect;
                end
            end
            ST_DWAIT: begin
                if (!dmem_ack_i) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl      = front_ctrl;
                    flush_inc = redirect;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                ctrl       = CTRL_INIT;
                state_d    = ST_INIT;
                init_cnt_d = INIT_LOAD;
            end
        endcase
        stall_inc = ((state_q == ST_RUN) || (state_q == ST_DWAIT)) && !ctrl.pc_write;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_LOAD;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign PCWrite_o    = ctrl.pc_write;
    assign IF_IDWrite_o = ctrl.ifid_write;
    assign IF_flush_o   = ctrl.if_flush;
    assign ID_bubble_o  = ctrl.id_bubble;
    assign pipe_hold_o  = ctrl.pipe_hold;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .clr_i (clr_cnt_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .clr_i (clr_cnt_i),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4). Every cycle
// the DUT outputs and counters are compared against a behavioural model that
// tracks "INIT cycles left", "waiting on data memory" and plain integer
// counters. A table of single-cycle vectors and hand-written sequences add
// fixed expected values on top.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // {PCWrite, IF_IDWrite, IF_flush, ID_bubble, pipe_hold}
    localparam logic [4:0] EXP_INIT   = 5'b00110;
    localparam logic [4:0] EXP_FREEZE = 5'b00001;
    localparam logic [4:0] EXP_LU     = 5'b00010;
    localparam logic [4:0] EXP_REDIR  = 5'b11100;
    localparam logic [4:0] EXP_FWAIT  = 5'b01100;
    localparam logic [4:0] EXP_NORMAL = 5'b11000;

    logic             clk_i;
    logic             rst_i;
    logic [4:0]       ID_rs_i;
    logic [4:0]       ID_rt_i;
    logic             ID_uses_rt_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             imem_ready_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             clr_cnt_i;
    logic             PCWrite_o;
    logic             IF_IDWrite_o;
    logic             IF_flush_o;
    logic             ID_bubble_o;
    logic             pipe_hold_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [4:0]       dut_ctrl;

    assign dut_ctrl = {PCWrite_o, IF_IDWrite_o, IF_flush_o, ID_bubble_o, pipe_hold_o};

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ID_rs_i        (ID_rs_i),
        .ID_rt_i        (ID_rt_i),
        .ID_uses_rt_i   (ID_uses_rt_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_rt_i        (EX_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .imem_ready_i   (imem_ready_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .clr_cnt_i      (clr_cnt_i),
        .PCWrite_o      (PCWrite_o),
        .IF_IDWrite_o   (IF_IDWrite_o),
        .IF_flush_o     (IF_flush_o),
        .ID_bubble_o    (ID_bubble_o),
        .pipe_hold_o    (pipe_hold_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       imem_rdy;
        logic       dreq;
        logic       dack;
        logic       clr;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [4:0] exp_ctrl;
    } vec_t;

    vec_t  vecs[$];
    stim_t cur_s;
    int    num_checks = 0;
    int    num_errors = 0;

    // Behavioural model state
    int m_init_left;
    bit m_waiting;
    int m_stall;
    int m_flush;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mkStim(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                     input logic mem_read, input logic [4:0] ex_rt, input logic br,
                                     input logic jmp, input logic imem_rdy, input logic dreq,
                                     input logic dack, input logic clr);
        stim_t s;
        s.rs = rs; s.rt = rt; s.uses_rt = uses_rt; s.mem_read = mem_read; s.ex_rt = ex_rt;
        s.br = br; s.jmp = jmp; s.imem_rdy = imem_rdy; s.dreq = dreq; s.dack = dack; s.clr = clr;
        return s;
    endfunction

    function automatic stim_t idleStim();
        return mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic addVec(input string name, input stim_t s, input logic [4:0] exp_ctrl);
        vec_t v;
        v.name = name; v.s = s; v.exp_ctrl = exp_ctrl;
        vecs.push_back(v);
    endtask

    // Expected controls from the rules, given the model's current situation.
    function automatic logic [4:0] modelCtrl(input stim_t s, output bit redirect);
        redirect = 1'b0;
        if (m_init_left > 0) return EXP_INIT;
        if (!s.dack && (m_waiting || s.dreq)) return EXP_FREEZE;
        if (s.mem_read && s.ex_rt != 5'd0 &&
            (s.ex_rt == s.rs || (s.uses_rt && s.ex_rt == s.rt))) return EXP_LU;
        if (s.br || s.jmp) begin
            redirect = 1'b1;
            return EXP_REDIR;
        end
        if (!s.imem_rdy) return EXP_FWAIT;
        return EXP_NORMAL;
    endfunction

    function automatic void modelReset();
        m_init_left = FLUSH_CYCLES;
        m_waiting   = 1'b0;
        m_stall     = 0;
        m_flush     = 0;
    endfunction

    // Drive a cycle's inputs just after the active edge, then compare at the
    // falling edge against the model.
    task automatic applyStimulus(input stim_t s);
        bit         redir;
        logic [4:0] exp_c;
        cur_s          = s;
        ID_rs_i        = s.rs;
        ID_rt_i        = s.rt;
        ID_uses_rt_i   = s.uses_rt;
        EX_MemRead_i   = s.mem_read;
        EX_rt_i        = s.ex_rt;
        branch_taken_i = s.br;
        jump_i         = s.jmp;
        imem_ready_i   = s.imem_rdy;
        dmem_req_i     = s.dreq;
        dmem_ack_i     = s.dack;
        clr_cnt_i      = s.clr;
        @(negedge clk_i);
        exp_c = modelCtrl(s, redir);
        checkOutput("model_ctrl", 32'(dut_ctrl), 32'(exp_c));
        checkOutput("model_stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        checkOutput("model_flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
    endtask

    // Advance the model across the next rising edge, then step the clock.
    task automatic advance();
        bit         redir;
        logic [4:0] exp_c;
        bit         counting;
        exp_c    = modelCtrl(cur_s, redir);
        counting = (m_init_left == 0);
        if (m_init_left > 0) m_init_left--;
        else m_waiting = !cur_s.dack && (m_waiting || cur_s.dreq);
        if (cur_s.clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (counting && !exp_c[4] && m_stall < CNT_MAX) m_stall++;
            if (counting && redir && m_flush < CNT_MAX) m_flush++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic runCycle(input stim_t s);
        applyStimulus(s);
        advance();
    endtask

    initial begin
        stim_t s;
        logic [4:0] lu_rs;
        lu_rs = 5'd5;

        // Table of single-cycle RUN-state vectors
        addVec("idle",          mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_NORMAL);
        addVec("lu_rs",         mkStim(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_LU);
        addVec("lu_r0",         mkStim(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_NORMAL);
        addVec("lu_rt",         mkStim(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_LU);
        addVec("rt_unused",     mkStim(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_NORMAL);
        addVec("no_memread",    mkStim(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_NORMAL);
        addVec("branch",        mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_REDIR);
        addVec("jump",          mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), EXP_REDIR);
        addVec("branch_lu_rt",  mkStim(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), EXP_LU);
        addVec("imem_wait",     mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), EXP_FWAIT);
        addVec("branch_imem",   mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), EXP_REDIR);
        addVec("lu_imem",       mkStim(5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), EXP_LU);
        addVec("dreq_dack",     mkStim(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), EXP_NORMAL);

        // Reset: INIT outputs while rst_i is high
        s = idleStim();
        cur_s = s;
        rst_i = 1'b1;
        ID_rs_i = s.rs; ID_rt_i = s.rt; ID_uses_rt_i = s.uses_rt; EX_MemRead_i = s.mem_read;
        EX_rt_i = s.ex_rt; branch_taken_i = s.br; jump_i = s.jmp; imem_ready_i = s.imem_rdy;
        dmem_req_i = s.dreq; dmem_ack_i = s.dack; clr_cnt_i = s.clr;
        modelReset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_ctrl", 32'(dut_ctrl), 32'(EXP_INIT));
        checkOutput("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        checkOutput("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Exactly FLUSH_CYCLES cycles of INIT, then normal fetch
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            applyStimulus(idleStim());
            checkOutput("init_ctrl", 32'(dut_ctrl), 32'(EXP_INIT));
            advance();
        end
        applyStimulus(idleStim());
        checkOutput("after_init_ctrl", 32'(dut_ctrl), 32'(EXP_NORMAL));
        advance();

        // Load-use on rs: one stall cycle counted
        s = idleStim();
        s.mem_read = 1'b1; s.ex_rt = lu_rs; s.rs = lu_rs;
        applyStimulus(s);
        checkOutput("lu_ctrl", 32'(dut_ctrl), 32'(EXP_LU));
        advance();
        applyStimulus(idleStim());
        checkOutput("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
        advance();

        // Branch flush counted, then branch with load-use on rt is not
        s = idleStim();
        s.br = 1'b1;
        runCycle(s);
        applyStimulus(idleStim());
        checkOutput("branch_flush_cnt", 32'(flush_cnt_o), 32'd1);
        advance();
        s = idleStim();
        s.br = 1'b1; s.mem_read = 1'b1; s.ex_rt = 5'd6; s.rt = 5'd6; s.uses_rt = 1'b1;
        applyStimulus(s);
        checkOutput("br_lu_ctrl", 32'(dut_ctrl), 32'(EXP_LU));
        advance();
        applyStimulus(idleStim());
        checkOutput("br_lu_flush_cnt", 32'(flush_cnt_o), 32'd1);
        checkOutput("br_lu_stall_cnt", 32'(stall_cnt_o), 32'd2);
        advance();

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].name, 32'(dut_ctrl), 32'(vecs[i].exp_ctrl));
            advance();
        end

        // Data memory wait: 3 frozen cycles, release on ack
        s = idleStim();
        s.clr = 1'b1;
        runCycle(s);
        s = idleStim();
        s.dreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("dwait_hold", 32'(dut_ctrl), 32'(EXP_FREEZE));
            advance();
        end
        s.dack = 1'b1;
        applyStimulus(s);
        checkOutput("dwait_ack_ctrl", 32'(dut_ctrl), 32'(EXP_NORMAL));
        advance();
        applyStimulus(idleStim());
        checkOutput("dwait_stall_cnt", 32'(stall_cnt_o), 32'd3);
        checkOutput("dwait_back_to_run", 32'(dut_ctrl), 32'(EXP_NORMAL));
        advance();

        // Branch held through a freeze acts in the ack cycle
        s = idleStim();
        s.dreq = 1'b1; s.br = 1'b1;
        runCycle(s);
        s.dack = 1'b1;
        applyStimulus(s);
        checkOutput("freeze_branch_release", 32'(dut_ctrl), 32'(EXP_REDIR));
        advance();

        // Instruction memory not ready for two cycles
        s = idleStim();
        s.imem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            checkOutput("imem_wait_ctrl", 32'(dut_ctrl), 32'(EXP_FWAIT));
            advance();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.uses_rt  = 1'($urandom_range(0, 1));
            s.mem_read = ($urandom_range(0, 9) < 4);
            s.ex_rt    = 5'($urandom_range(0, 3));
            s.br       = ($urandom_range(0, 9) < 2);
            s.jmp      = ($urandom_range(0, 9) < 1);
            s.imem_rdy = ($urandom_range(0, 9) < 8);
            s.dreq     = ($urandom_range(0, 9) < 2);
            s.dack     = ($urandom_range(0, 9) < 4);
            s.clr      = ($urandom_range(0, 31) == 0);
            runCycle(s);
        end

        // Saturation: 2^CNT_W+5 stall cycles then clear
        s = idleStim();
        s.clr = 1'b1;
        runCycle(s);
        s = idleStim();
        s.imem_rdy = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) runCycle(s);
        applyStimulus(idleStim());
        checkOutput("sat_stall_cnt", 32'(stall_cnt_o), 32'(CNT_MAX));
        advance();
        s = idleStim();
        s.clr = 1'b1; s.imem_rdy = 1'b0;
        runCycle(s);
        applyStimulus(idleStim());
        checkOutput("clr_stall_cnt", 32'(stall_cnt_o), 32'd0);
        advance();

        // Reset in the middle of DWAIT
        s = idleStim();
        s.dreq = 1'b1;
        runCycle(s);
        applyStimulus(s);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_ctrl", 32'(dut_ctrl), 32'(EXP_INIT));
        checkOutput("mid_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        checkOutput("mid_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        modelReset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES + 3; i++) runCycle(idleStim());

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives PC write-enable, the IF/ID register's write/flush controls, the ID/EX bubble insert and a back-end freeze. Inputs are load-use hazards, ID-resolved branches and jumps, instruction-fetch readiness and data-memory wait states. It holds a small FSM for post-reset flushing and multi-cycle data-memory stalls, plus saturating stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 2, cycles after reset release during which fetch is held and IF/ID is flushed (>=1)
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
ID_rs_i  in  5  rs field of instruction in ID
ID_rt_i  in  5  rt field of instruction in ID
ID_uses_rt_i  in  1  ID instruction reads rt as a source
EX_MemRead_i  in  1  instruction in EX is a load
EX_rt_i  in  5  destination of load in EX
branch_taken_i  in  1  branch in ID resolved taken
jump_i  in  1  jump in ID
imem_ready_i  in  1  instruction memory returns valid word this cycle
dmem_req_i  in  1  MEM stage access active
dmem_ack_i  in  1  data memory completes access this cycle
clr_cnt_i  in  1  synchronous clear of counters
PCWrite_o  out  1  PC register update enable
IF_IDWrite_o  out  1  IF/ID write enable
IF_flush_o  out  1  IF/ID instruction flush (zero)
ID_bubble_o  out  1  zero control bits entering ID/EX
pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0 outside INIT
flush_cnt_o  out  CNT_W  branch/jump flushes

Behaviour:
- Clock and reset: single clock clk_i; rst_i asynchronous, active-high. Reset forces state=INIT, init counter=FLUSH_CYCLES-1, both perf counters=0.
- Control outputs are combinational from state and inputs, so they are valid before the posedge that the pipeline registers sample on.
- INIT: PCWrite=0, IF_IDWrite=0, IF_flush=1, ID_bubble=1, pipe_hold=0. These are also the output values while rst_i is high. The counter decrements each cycle. When it is 0, go to RUN on the next edge, so INIT lasts exactly FLUSH_CYCLES cycles.
- RUN, fixed priority, first match wins:
  1. dmem_req_i && !dmem_ack_i: PCWrite=0, IF_IDWrite=0, IF_flush=0, ID_bubble=0, pipe_hold=1; next=DWAIT.
  2. load-use: EX_MemRead_i && EX_rt_i!=0 && (EX_rt_i==ID_rs_i || (ID_uses_rt_i && EX_rt_i==ID_rt_i)). Outputs: PCWrite=0, IF_IDWrite=0, IF_flush=0, ID_bubble=1, pipe_hold=0.
  3. branch_taken_i || jump_i: PCWrite=1, IF_IDWrite=1, IF_flush=1, ID_bubble=0, pipe_hold=0.
  4. !imem_ready_i: PCWrite=0, IF_IDWrite=1, IF_flush=1 (NOP into ID), ID_bubble=0, pipe_hold=0.
  5. otherwise: PCWrite=1, IF_IDWrite=1, IF_flush=0, ID_bubble=0, pipe_hold=0.
- DWAIT:
  - While !dmem_ack_i: outputs as in RUN rule 1.
  - In the ack cycle: pipe_hold=0, outputs from RUN rules 2-5; next=RUN.
- Simultaneous events:
  - Load-use together with branch/jump: the stall wins and the redirect is suppressed. The branch stays in ID and is re-evaluated the next cycle with forwarded operands.
  - Branch during a freeze: the branch stays held in ID and is acted on in the first unfrozen cycle.
  - dmem_req_i && dmem_ack_i in the same RUN cycle: no stall.
- Load-use insertion is one cycle. The hazard self-clears once the load advances; no extra state is needed.
- Counters:
  - stall_cnt increments in any RUN/DWAIT cycle with PCWrite_o=0.
  - flush_cnt increments in any cycle where rule 3 fires.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt_i zeroes both and takes priority over increment in that cycle.
- Asserting rst_i mid-operation (e.g. in DWAIT) returns to INIT immediately. Counters clear.

Decomposition:
- Shared package ctrl_pkg: state encoding (INIT=2'd0, RUN=2'd1, DWAIT=2'd2), REG_ZERO=5'd0.
- One natural sub-module: sat_counter (CNT_W-wide, inc/clr, saturating), instantiated twice.

Test Plan:
- Reset with FLUSH_CYCLES=2, release rst_i -> IF_flush=1, PCWrite=0 for exactly 2 cycles; then PCWrite=1, IF_IDWrite=1, flush=0.
- EX_MemRead=1, EX_rt=5, ID_rs=5 -> one cycle PCWrite=0, IF_IDWrite=0, ID_bubble=1; stall_cnt 0->1. Same with EX_rt=0 -> no stall.
- branch_taken=1, no hazard -> PCWrite=1, IF_flush=1; flush_cnt 0->1. Add a concurrent load-use on rt with ID_uses_rt=1 -> stall only, flush_cnt unchanged.
- dmem_req=1, ack low 3 cycles then high -> pipe_hold=1 for 3 cycles, 0 in ack cycle; stall_cnt +3; state back to RUN.
- imem_ready=0 for 2 cycles -> PCWrite=0, IF_IDWrite=1, IF_flush=1 each cycle. Assert rst_i mid-DWAIT -> INIT outputs immediately, counters 0.
- Drive 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_cnt holds 15. Pulse clr_cnt_i -> 0 next cycle.
